// File: rtl/matvec_param.sv
// Streaming matrix-vector engine: y = W*x for an MxN signed matrix held in RAM,
// with matrix reuse across vectors and an optional ReLU on the result.

module matvec_mult #(
    parameter int WIDTH  = 14,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] p
);
    logic signed [2*WIDTH-1:0] prod_c;

    assign prod_c = a * b;

    generate
        if (STAGES == 0) begin : g_comb
            assign p = prod_c;
        end else begin : g_pipe
            logic [STAGES-1:0][2*WIDTH-1:0] pipe_q;

            always_ff @(posedge clk) begin
                pipe_q[0] <= prod_c;
                for (int i = 1; i < STAGES; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign p = $signed(pipe_q[STAGES-1]);
        end
    endgenerate
endmodule

module matvec_param #(
    parameter int M           = 8,
    parameter int N           = 8,
    parameter int WIDTH       = 14,
    parameter int MULT_STAGES = 2,
    parameter int RELU        = 0,
    localparam int ACC_W      = 2*WIDTH + $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] input_data,
    input  logic             new_matrix,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [ACC_W-1:0] output_data
);
    localparam int MN   = M * N;
    localparam int WA_W = $clog2(MN);
    localparam int XA_W = $clog2(N);
    localparam int R_W  = (M > 1) ? $clog2(M) : 1;
    localparam int DC_W = $clog2(MULT_STAGES + 2);
    localparam int P_W  = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, DRAIN, OUTPUT} state_t;

    state_t            state_q, state_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [XA_W-1:0]   xaddr_q, xaddr_d;
    logic [R_W-1:0]    row_q, row_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    logic              matrix_loaded_q, matrix_loaded_d;
    logic              input_ready_q, input_ready_d;
    logic              output_valid_q, output_valid_d;
    logic [ACC_W-1:0]  output_data_q, output_data_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic              in_xfer;
    logic              w_we;
    logic              x_we;
    logic              issue;
    logic [ACC_W-1:0]  result;

    logic [WIDTH-1:0]         w_mem [MN];
    logic [WIDTH-1:0]         x_mem [N];
    logic signed [WIDTH-1:0]  w_rd_q;
    logic signed [WIDTH-1:0]  x_rd_q;
    logic signed [P_W-1:0]    prod;
    logic [ACC_W-1:0]         prod_ext;

    // Valid and first-column tags ride alongside the data: index 0 is the RAM
    // read register, index MULT_STAGES is the multiplier output.
    logic [MULT_STAGES:0]     vld_pipe_q;
    logic [MULT_STAGES:0]     first_pipe_q;

    assign in_xfer      = input_valid && input_ready_q;
    assign input_ready  = input_ready_q;
    assign output_valid = output_valid_q;
    assign output_data  = output_data_q;

    always_comb begin
        state_d         = state_q;
        waddr_d         = waddr_q;
        xaddr_d         = xaddr_q;
        row_d           = row_q;
        drain_d         = drain_q;
        matrix_loaded_d = matrix_loaded_q;
        output_valid_d  = output_valid_q;
        output_data_d   = output_data_q;
        w_we            = 1'b0;
        x_we            = 1'b0;
        issue           = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    if (new_matrix || !matrix_loaded_q) begin
                        w_we    = 1'b1;
                        waddr_d = WA_W'(1);
                        state_d = LOAD_W;
                    end else begin
                        x_we    = 1'b1;
                        xaddr_d = XA_W'(1);
                        state_d = LOAD_X;
                    end
                end
            end
            LOAD_W: begin
                if (in_xfer) begin
                    w_we = 1'b1;
                    if (waddr_q == WA_W'(MN - 1)) begin
                        waddr_d         = '0;
                        matrix_loaded_d = 1'b1;
                        state_d         = LOAD_X;
                    end else begin
                        waddr_d = waddr_q + WA_W'(1);
                    end
                end
            end
            LOAD_X: begin
                if (in_xfer) begin
                    x_we = 1'b1;
                    if (xaddr_q == XA_W'(N - 1)) begin
                        xaddr_d = '0;
                        row_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        xaddr_d = xaddr_q + XA_W'(1);
                    end
                end
            end
            COMPUTE: begin
                // Rows are stored back to back, so the W address simply keeps
                // counting across rows and wraps after the last one.
                issue   = 1'b1;
                waddr_d = (waddr_q == WA_W'(MN - 1)) ? '0 : waddr_q + WA_W'(1);
                if (xaddr_q == XA_W'(N - 1)) begin
                    xaddr_d = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    xaddr_d = xaddr_q + XA_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DC_W'(MULT_STAGES + 1)) begin
                    output_valid_d = 1'b1;
                    output_data_d  = result;
                    state_d        = OUTPUT;
                end else begin
                    drain_d = drain_q + DC_W'(1);
                end
            end
            OUTPUT: begin
                if (output_ready) begin
                    output_valid_d = 1'b0;
                    if (row_q == R_W'(M - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d   = row_q + R_W'(1);
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        input_ready_d = (state_d == IDLE) || (state_d == LOAD_W) || (state_d == LOAD_X);
    end

    assign prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    assign result   = ((RELU != 0) && acc_q[ACC_W-1]) ? '0 : acc_q;

    always_comb begin
        acc_d = acc_q;
        if (vld_pipe_q[MULT_STAGES]) begin
            acc_d = first_pipe_q[MULT_STAGES] ? prod_ext : acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            waddr_q         <= '0;
            xaddr_q         <= '0;
            row_q           <= '0;
            drain_q         <= '0;
            matrix_loaded_q <= 1'b0;
            input_ready_q   <= 1'b0;
            output_valid_q  <= 1'b0;
            output_data_q   <= '0;
            acc_q           <= '0;
            vld_pipe_q      <= '0;
            first_pipe_q    <= '0;
        end else begin
            state_q         <= state_d;
            waddr_q         <= waddr_d;
            xaddr_q         <= xaddr_d;
            row_q           <= row_d;
            drain_q         <= drain_d;
            matrix_loaded_q <= matrix_loaded_d;
            input_ready_q   <= input_ready_d;
            output_valid_q  <= output_valid_d;
            output_data_q   <= output_data_d;
            acc_q           <= acc_d;
            vld_pipe_q[0]   <= issue;
            first_pipe_q[0] <= issue && (xaddr_q == '0);
            for (int i = 1; i <= MULT_STAGES; i++) begin
                vld_pipe_q[i]   <= vld_pipe_q[i-1];
                first_pipe_q[i] <= first_pipe_q[i-1];
            end
        end
    end

    // Storage is not reset; both ports share the load/compute address counters.
    always_ff @(posedge clk) begin
        if (w_we) w_mem[waddr_q] <= input_data;
        if (x_we) x_mem[xaddr_q] <= input_data;
        w_rd_q <= $signed(w_mem[waddr_q]);
        x_rd_q <= $signed(x_mem[xaddr_q]);
    end

    matvec_mult #(
        .WIDTH  (WIDTH),
        .STAGES (MULT_STAGES)
    ) u_mult (
        .clk (clk),
        .a   (w_rd_q),
        .b   (x_rd_q),
        .p   (prod)
    );
endmodule

// File: doc/matvec_param.md
Name: matvec_param

Overview:
Parametrised successor to the fixed 8x8 matrix-vector engine. It computes y = W·x for an M-row by N-column signed matrix W and an N-element vector x. All operands arrive on one streaming input port with a valid/ready handshake, and the M results leave one per handshake. The block adds three things the fixed engine lacks: arbitrary M and N, matrix reuse across vectors, and an optional ReLU output stage. It sits between the input stream interface and the downstream consumer in the CNN datapath, and internally contains two RAMs, a pipelined multiplier, an accumulator and the controller FSM.

Parameters:
M, 8, number of matrix rows (outputs per vector), >=1
N, 8, number of matrix columns (vector length), >=2
WIDTH, 14, signed operand width
MULT_STAGES, 2, pipeline registers inside the multiplier, 0..8
RELU, 0, 1 = clamp negative results to 0 before output
ACC_W, 2*WIDTH+$clog2(N), accumulator and output width (derived; not to be overridden)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high
input_valid  input  1  input_data valid
input_ready  output  1  block accepts input_data this cycle
input_data  input  WIDTH  signed operand word
new_matrix  input  1  sampled on first accepted word of a transaction; 1 = load matrix then vector
output_valid  output  1  output_data valid
output_ready  input  1  consumer accepts output_data
output_data  output  ACC_W  signed result y[r]

Behaviour:
- Reset values: input_ready=0, output_valid=0, output_data=0, FSM=IDLE, all counters=0, matrix_loaded=0. RAM contents are not reset.
- A word transfers on any cycle where input_valid && input_ready. An output transfers on any cycle where output_valid && output_ready.
- FSM states: IDLE, LOAD_W, LOAD_X, COMPUTE, DRAIN, OUTPUT.
- IDLE: input_ready=1 from the first cycle after reset. On the first accepted word:
  - If new_matrix=1, or matrix_loaded=0, the word is stored as W[0][0] and the FSM goes to LOAD_W.
  - Otherwise the word is stored as x[0] and the FSM goes to LOAD_X.
- LOAD_W: input_ready=1. Words are taken in row-major order, W[r][c] at address r*N+c. After word M*N-1 is accepted, matrix_loaded is set to 1 and the FSM goes to LOAD_X. new_matrix is ignored after the first word.
- LOAD_X: input_ready=1. After word N-1 is accepted, input_ready falls in the next cycle and the FSM goes to COMPUTE with row=0.
- input_ready is 0 in COMPUTE, DRAIN and OUTPUT. Stalls (input_valid=0) may occur at any point during loading; the address counters hold while stalled.
- COMPUTE: issues one RAM read pair per cycle for c=0..N-1, N cycles. Accumulator is cleared as c=0 enters the multiplier.
- DRAIN: waits MULT_STAGES+2 cycles (1 RAM read + multiplier + accumulate), then goes to OUTPUT.
- Latency: output_valid for every row rises exactly N+MULT_STAGES+2 cycles after COMPUTE entry for that row.
- OUTPUT: output_valid=1 and output_data hold stable until the handshake.
  - If RELU=1 and the sum is <0, output_data=0.
  - On handshake, output_valid falls in the next cycle. If row<M-1, row increments and the FSM returns to COMPUTE. If row=M-1, the FSM returns to IDLE.
- Arithmetic: full-precision signed product of 2*WIDTH bits, sign-extended to ACC_W. ACC_W is sized so that no overflow is possible, so no saturation logic is needed.
- Wrap-around: address counters wrap to 0 at the end of each load and compute pass. The row counter wraps to 0 at M-1.
- Reset mid-operation (any state): returns to reset values next cycle, any pending output is dropped, and matrix_loaded=0. The next transaction therefore always reloads W, regardless of new_matrix.
- output_ready held high continuously: outputs arrive spaced N+MULT_STAGES+3 cycles apart. There is no overlap between rows.

Test Plan:
1. Defaults, new_matrix=1, W=identity, x=1..8 -> outputs 1,2,…,8 in order. First output_valid exactly 12 cycles after COMPUTE entry.
2. After test 1, new_matrix=0, send only 8 words x=10..17 -> W is reused, outputs 10..17. input_ready drops after exactly 8 accepted words.
3. W all -8192, x all -8192 -> every output = 536870912 (fits in ACC_W=31, no wrap). Then W all -8192, x all 8191 -> every output = -536805376.
4. output_ready held low for 5 cycles on row 3 -> output_valid stays 1, output_data unchanged, and no row-4 output appears until the handshake.
5. RELU=1, W row r = -(r+1)·ones, x=ones -> all outputs 0. Then negate W -> outputs 8,16,…,64.
6. reset asserted after 20 matrix words, then a transaction with new_matrix=0 -> block still loads 64+8 words, with correct outputs for the newly sent W.
